// File: rtl/minimac3_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : minimac3_ctrl_if
// Description : CSR bus plus RX/TX handshake bundle for minimac3_ctrl.
//               slave  = the control stage, master = CSR host and MAC side.
// Revision    : 1.0 - initial release
// ============================================================================
interface minimac3_ctrl_if;
  logic [13:0] csr_a;
  logic        csr_we;
  logic [31:0] csr_di;
  logic [31:0] csr_do;
  logic        irq;
  logic        rx_ready_0;
  logic        rx_done_0;
  logic [10:0] rx_count_0;
  logic        rx_ready_1;
  logic        rx_done_1;
  logic [10:0] rx_count_1;
  logic        tx_start;
  logic        tx_done;
  logic [10:0] tx_count;

  modport master (
    output csr_a, csr_we, csr_di, rx_done_0, rx_count_0, rx_done_1, rx_count_1, tx_done,
    input  csr_do, irq, rx_ready_0, rx_ready_1, tx_start, tx_count
  );

  modport slave (
    input  csr_a, csr_we, csr_di, rx_done_0, rx_count_0, rx_done_1, rx_count_1, tx_done,
    output csr_do, irq, rx_ready_0, rx_ready_1, tx_start, tx_count
  );
endinterface
`default_nettype wire

// File: rtl/minimac3_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : minimac3_ctrl
// Description : System-side control for the minimac3 MAC: CSR decode, two RX
//               buffer ownership FSMs, TX launch FSM and a level interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module minimac3_ctrl #(
  parameter logic [3:0] CSR_ADDR = 4'h0
) (
  input wire            sys_clk,
  input wire            sys_rst,
  minimac3_ctrl_if.slave bus
);

  // Slot ownership states (also the software-visible encoding)
  localparam logic [1:0] SLOT_EMPTY   = 2'd0;
  localparam logic [1:0] SLOT_LOADED  = 2'd1;
  localparam logic [1:0] SLOT_PENDING = 2'd2;

  localparam logic [0:0] TX_IDLE = 1'b0;
  localparam logic [0:0] TX_BUSY = 1'b1;

  localparam logic [2:0] REG_SLOT0_STATE = 3'd0;
  localparam logic [2:0] REG_SLOT0_COUNT = 3'd1;
  localparam logic [2:0] REG_SLOT1_STATE = 3'd2;
  localparam logic [2:0] REG_SLOT1_COUNT = 3'd3;
  localparam logic [2:0] REG_TX_COUNT    = 3'd4;
  localparam logic [2:0] REG_STATUS      = 3'd5;
  localparam logic [2:0] REG_ENABLE      = 3'd6;

  // ---------------------------------------------------------------- decode
  logic       w_sel;
  logic       w_wr;
  logic [2:0] w_idx;
  logic [1:0] w_slot_wr;
  logic       w_tx_wr;
  logic       w_stat_wr;
  logic       w_en_wr;
  logic       w_unused;

  assign w_sel        = (bus.csr_a[13:10] == CSR_ADDR);
  assign w_idx        = bus.csr_a[2:0];
  assign w_wr         = bus.csr_we & w_sel;
  assign w_slot_wr[0] = w_wr & (w_idx == REG_SLOT0_STATE);
  assign w_slot_wr[1] = w_wr & (w_idx == REG_SLOT1_STATE);
  assign w_tx_wr      = w_wr & (w_idx == REG_TX_COUNT);
  assign w_stat_wr    = w_wr & (w_idx == REG_STATUS);
  assign w_en_wr      = w_wr & (w_idx == REG_ENABLE);
  // Address bits between the bank field and the index, and data above the
  // widest field, carry no meaning for this block.
  assign w_unused     = ^{bus.csr_a[9:3], bus.csr_di[31:11]};

  // ------------------------------------------------------------- RX slots
  logic [1:0]  slot_state_q [2];
  logic [1:0]  slot_state_d [2];
  logic [10:0] slot_count_q [2];
  logic [10:0] slot_count_d [2];
  logic [1:0]  rx_ready_q;
  logic [1:0]  rx_ready_d;
  logic [1:0]  w_rx_done;
  logic [10:0] w_rx_count [2];
  logic        w_rx_pending;

  assign w_rx_done     = {bus.rx_done_1, bus.rx_done_0};
  assign w_rx_count[0] = bus.rx_count_0;
  assign w_rx_count[1] = bus.rx_count_1;
  assign w_rx_pending  = (slot_state_q[0] == SLOT_PENDING) | (slot_state_q[1] == SLOT_PENDING);

  // Slot next-state: a completing frame outranks a same-cycle CSR write
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      slot_state_d[n] = slot_state_q[n];
      slot_count_d[n] = slot_count_q[n];
      case (slot_state_q[n])
        SLOT_EMPTY: begin
          if (w_slot_wr[n] && (bus.csr_di[1:0] == SLOT_LOADED)) slot_state_d[n] = SLOT_LOADED;
        end
        SLOT_LOADED: begin
          if (w_rx_done[n]) begin
            slot_state_d[n] = SLOT_PENDING;
            slot_count_d[n] = w_rx_count[n];
          end else if (w_slot_wr[n] && (bus.csr_di[1:0] == SLOT_EMPTY)) begin
            slot_state_d[n] = SLOT_EMPTY;
          end
        end
        SLOT_PENDING: begin
          if (w_slot_wr[n] && (bus.csr_di[1:0] == SLOT_EMPTY)) slot_state_d[n] = SLOT_EMPTY;
        end
        default: slot_state_d[n] = SLOT_EMPTY;
      endcase
      rx_ready_d[n] = (slot_state_d[n] == SLOT_LOADED);
    end
  end

  // Slot state, captured byte counts and the registered ready strobes
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int n = 0; n < 2; n++) begin
        slot_state_q[n] <= SLOT_EMPTY;
        slot_count_q[n] <= '0;
      end
      rx_ready_q <= '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        slot_state_q[n] <= slot_state_d[n];
        slot_count_q[n] <= slot_count_d[n];
      end
      rx_ready_q <= rx_ready_d;
    end
  end

  // ------------------------------------------------------------------ TX
  logic [0:0]  tx_state_q;
  logic [0:0]  tx_state_d;
  logic [10:0] tx_count_q;
  logic [10:0] tx_count_d;
  logic        tx_start_q;
  logic        tx_start_d;
  logic        tx_event_q;
  logic        tx_event_d;
  logic        w_tx_finish;

  // TX launch/complete; tx_count is only reloaded on an accepted launch
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_count_d  = tx_count_q;
    tx_start_d  = 1'b0;
    w_tx_finish = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (w_tx_wr && (bus.csr_di[10:0] != 11'd0)) begin
          tx_state_d = TX_BUSY;
          tx_count_d = bus.csr_di[10:0];
          tx_start_d = 1'b1;
        end
      end
      TX_BUSY: begin
        if (bus.tx_done) begin
          tx_state_d  = TX_IDLE;
          w_tx_finish = 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    tx_event_d = tx_event_q;
    if (w_stat_wr && bus.csr_di[1]) tx_event_d = 1'b0;
    if (w_tx_finish)                tx_event_d = 1'b1;
  end

  // TX state, held byte count, launch pulse and completion event
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      tx_state_q <= TX_IDLE;
      tx_count_q <= '0;
      tx_start_q <= 1'b0;
      tx_event_q <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_count_q <= tx_count_d;
      tx_start_q <= tx_start_d;
      tx_event_q <= tx_event_d;
    end
  end

  // ------------------------------------------------- enables, read, irq
  logic        rx_en_q;
  logic        tx_en_q;
  logic [31:0] csr_do_q;
  logic        irq_q;
  logic [31:0] w_rdata;

  // Read mux over current register contents; foreign banks read zero
  always_comb begin
    w_rdata = '0;
    if (w_sel) begin
      case (w_idx)
        REG_SLOT0_STATE: w_rdata[1:0]  = slot_state_q[0];
        REG_SLOT0_COUNT: w_rdata[10:0] = slot_count_q[0];
        REG_SLOT1_STATE: w_rdata[1:0]  = slot_state_q[1];
        REG_SLOT1_COUNT: w_rdata[10:0] = slot_count_q[1];
        REG_TX_COUNT:    w_rdata[10:0] = tx_count_q;
        REG_STATUS:      w_rdata[2:0]  = {(tx_state_q == TX_BUSY), tx_event_q, w_rx_pending};
        REG_ENABLE:      w_rdata[1:0]  = {tx_en_q, rx_en_q};
        default:         w_rdata       = '0;
      endcase
    end
  end

  // Enable bits, registered read data and the level interrupt
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rx_en_q  <= 1'b0;
      tx_en_q  <= 1'b0;
      csr_do_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      if (w_en_wr) begin
        rx_en_q <= bus.csr_di[0];
        tx_en_q <= bus.csr_di[1];
      end
      csr_do_q <= w_rdata;
      irq_q    <= (w_rx_pending & rx_en_q) | (tx_event_q & tx_en_q);
    end
  end

  assign bus.csr_do     = csr_do_q;
  assign bus.irq        = irq_q;
  assign bus.rx_ready_0 = rx_ready_q[0];
  assign bus.rx_ready_1 = rx_ready_q[1];
  assign bus.tx_start   = tx_start_q;
  assign bus.tx_count   = tx_count_q;

endmodule
`default_nettype wire

// File: tb/tb_minimac3_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_minimac3_ctrl
// Description : Scoreboard bench for minimac3_ctrl with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_minimac3_ctrl;
  localparam logic [3:0] BANK = 4'h0;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;

  minimac3_ctrl_if bus();

  minimac3_ctrl #(.CSR_ADDR(BANK)) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus    (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------------------------------------------- reference model
  int m_slot [2];   // 0 empty, 1 handed to MAC, 2 frame waiting for software
  int m_cnt  [2];
  int m_txcnt;
  bit m_busy, m_ev, m_rxen, m_txen;
  bit e_irq, e_start;
  bit e_rdy [2];
  int e_txcnt;
  int rd_q [$];
  int tx_q [$];
  bit rd_issue = 1'b0;

  function automatic int read_reg(int idx);
    bit rxp;
    rxp = (m_slot[0] == 2) || (m_slot[1] == 2);
    case (idx)
      0: return m_slot[0];
      1: return m_cnt[0];
      2: return m_slot[1];
      3: return m_cnt[1];
      4: return m_txcnt;
      5: return (m_busy ? 4 : 0) + (m_ev ? 2 : 0) + (rxp ? 1 : 0);
      6: return (m_txen ? 2 : 0) + (m_rxen ? 1 : 0);
      default: return 0;
    endcase
  endfunction

  function automatic void model_reset();
    for (int n = 0; n < 2; n++) begin
      m_slot[n] = 0; m_cnt[n] = 0; e_rdy[n] = 1'b0;
    end
    m_txcnt = 0; m_busy = 0; m_ev = 0; m_rxen = 0; m_txen = 0;
    e_irq = 0; e_start = 0; e_txcnt = 0;
    rd_q.delete();
    tx_q.delete();
  endfunction

  function automatic void model_step();
    bit sel, wr, rxp, w, d, set;
    int idx, v, c, di;
    sel = (bus.csr_a[13:10] == BANK);
    idx = int'(bus.csr_a[2:0]);
    wr  = bus.csr_we && sel;
    di  = int'(bus.csr_di[10:0]);
    rxp = (m_slot[0] == 2) || (m_slot[1] == 2);
    e_irq = (rxp && m_rxen) || (m_ev && m_txen);
    if (rd_issue) rd_q.push_back(sel ? read_reg(idx) : 0);
    for (int n = 0; n < 2; n++) begin
      v = int'(bus.csr_di[1:0]);
      w = wr && (idx == 2 * n);
      d = (n == 0) ? bus.rx_done_0 : bus.rx_done_1;
      c = (n == 0) ? int'(bus.rx_count_0) : int'(bus.rx_count_1);
      if (m_slot[n] == 1 && d) begin
        m_slot[n] = 2; m_cnt[n] = c;
      end else if (w && v == 0 && m_slot[n] != 0) begin
        m_slot[n] = 0;
      end else if (w && v == 1 && m_slot[n] == 0) begin
        m_slot[n] = 1;
      end
      e_rdy[n] = (m_slot[n] == 1);
    end
    e_start = 0;
    set = 0;
    if (!m_busy && wr && idx == 4 && di != 0) begin
      m_busy = 1; m_txcnt = di; e_start = 1; tx_q.push_back(di);
    end else if (m_busy && bus.tx_done) begin
      m_busy = 0; set = 1;
    end
    if (set) m_ev = 1;
    else if (wr && idx == 5 && bus.csr_di[1]) m_ev = 0;
    if (wr && idx == 6) begin
      m_rxen = bus.csr_di[0]; m_txen = bus.csr_di[1];
    end
    e_txcnt = m_txcnt;
  endfunction

  // Model advances on the same edges as the design
  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) model_reset();
    else         model_step();
  end

  // ------------------------------------------------------------- monitor
  always @(negedge sys_clk) begin
    if (sys_rst) begin
      check("reset_outputs", {bus.csr_do, bus.irq, bus.rx_ready_0, bus.rx_ready_1,
                              bus.tx_start, bus.tx_count}, 64'd0);
    end else begin
      if (rd_q.size() > 0) check("csr_do", bus.csr_do, rd_q.pop_front());
      check("irq", bus.irq, e_irq);
      check("rx_ready_0", bus.rx_ready_0, e_rdy[0]);
      check("rx_ready_1", bus.rx_ready_1, e_rdy[1]);
      check("tx_count", bus.tx_count, e_txcnt);
      check("tx_start", bus.tx_start, e_start);
      if (bus.tx_start) begin
        if (tx_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL tx_start_unexpected: actual 1 required 0 at %0t", $time);
        end else begin
          check("tx_launch_count", bus.tx_count, tx_q.pop_front());
        end
      end
    end
  end

  // ------------------------------------------------------------- driver
  task automatic drive(input logic [3:0] bank, input logic [2:0] idx, input logic we,
                       input logic [31:0] di, input logic rd,
                       input logic d0, input logic [10:0] c0,
                       input logic d1, input logic [10:0] c1, input logic td);
    bus.csr_a      = {bank, 7'd0, idx};
    bus.csr_we     = we;
    bus.csr_di     = di;
    rd_issue       = rd;
    bus.rx_done_0  = d0;
    bus.rx_count_0 = c0;
    bus.rx_done_1  = d1;
    bus.rx_count_1 = c1;
    bus.tx_done    = td;
    @(negedge sys_clk);
  endtask

  task automatic idle();
    drive(BANK, 3'd0, 1'b0, 32'd0, 1'b0, 1'b0, 11'd0, 1'b0, 11'd0, 1'b0);
  endtask

  task automatic wr(input logic [2:0] idx, input logic [31:0] di);
    drive(BANK, idx, 1'b1, di, 1'b1, 1'b0, 11'd0, 1'b0, 11'd0, 1'b0);
  endtask

  task automatic rd(input logic [2:0] idx);
    drive(BANK, idx, 1'b0, 32'd0, 1'b1, 1'b0, 11'd0, 1'b0, 11'd0, 1'b0);
  endtask

  task automatic tx_done_pulse();
    drive(BANK, 3'd0, 1'b0, 32'd0, 1'b0, 1'b0, 11'd0, 1'b0, 11'd0, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0]  bank;
    logic [2:0]  idx;
    logic [31:0] di;

    // Reset held with random inputs
    for (int i = 0; i < 6; i++) begin
      bus.csr_a      = 14'($urandom);
      bus.csr_we     = 1'($urandom);
      bus.csr_di     = $urandom;
      bus.rx_done_0  = 1'($urandom);
      bus.rx_count_0 = 11'($urandom);
      bus.rx_done_1  = 1'($urandom);
      bus.rx_count_1 = 11'($urandom);
      bus.tx_done    = 1'($urandom);
      @(negedge sys_clk);
    end
    sys_rst = 1'b0;
    idle();
    for (int i = 0; i < 7; i++) begin
      rd(3'(i));
      check("reset_read", bus.csr_do, 0);
    end

    // Slot 0 receive and reclaim
    wr(3'd6, 32'd1);
    wr(3'd0, 32'd1);
    check("rdy0_after_load", bus.rx_ready_0, 1);
    drive(BANK, 3'd0, 1'b0, 32'd0, 1'b0, 1'b1, 11'd64, 1'b0, 11'd0, 1'b0);
    check("rdy0_after_done", bus.rx_ready_0, 0);
    idle();
    check("irq_rx_pending", bus.irq, 1);
    rd(3'd0);
    check("slot0_pending", bus.csr_do, 2);
    rd(3'd1);
    check("slot0_count", bus.csr_do, 64);
    wr(3'd0, 32'd0);
    idle();
    check("irq_rx_cleared", bus.irq, 0);

    // rx_done beats a same-cycle CSR write on slot 1
    wr(3'd0, 32'd1);
    wr(3'd2, 32'd1);
    drive(BANK, 3'd2, 1'b1, 32'd0, 1'b0, 1'b0, 11'd0, 1'b1, 11'd1514, 1'b0);
    rd(3'd2);
    check("slot1_done_wins", bus.csr_do, 2);
    rd(3'd3);
    check("slot1_count", bus.csr_do, 1514);
    rd(3'd0);
    check("slot0_still_loaded", bus.csr_do, 1);
    wr(3'd0, 32'd0);
    wr(3'd2, 32'd0);

    // TX launch, busy lockout, completion event and W1C
    wr(3'd6, 32'd3);
    wr(3'd4, 32'd60);
    check("tx_start_pulse", bus.tx_start, 1);
    check("tx_count_60", bus.tx_count, 60);
    idle();
    check("tx_start_single", bus.tx_start, 0);
    wr(3'd4, 32'd100);
    check("tx_busy_no_pulse", bus.tx_start, 0);
    check("tx_count_held", bus.tx_count, 60);
    tx_done_pulse();
    idle();
    check("irq_tx_event", bus.irq, 1);
    rd(3'd5);
    check("status_tx_event", bus.csr_do, 2);
    wr(3'd5, 32'd2);
    idle();
    check("irq_after_w1c", bus.irq, 0);

    // Zero-length TX is ignored; foreign bank is inert
    wr(3'd4, 32'd0);
    check("tx_zero_no_start", bus.tx_start, 0);
    rd(3'd5);
    check("status_idle", bus.csr_do, 0);
    wr(3'd0, 32'd1);
    drive(4'h3, 3'd0, 1'b1, 32'd0, 1'b1, 1'b0, 11'd0, 1'b0, 11'd0, 1'b0);
    check("foreign_bank_read", bus.csr_do, 0);
    rd(3'd0);
    check("foreign_bank_no_write", bus.csr_do, 1);
    check("foreign_bank_rdy", bus.rx_ready_0, 1);

    // Randomized traffic against the model, with one mid-run reset
    for (int i = 0; i < 1500; i++) begin
      if (i == 750) begin
        #3 sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
      end
      bank = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : BANK;
      idx  = 3'($urandom_range(0, 7));
      di   = $urandom;
      if ($urandom_range(0, 3) == 0) di[10:0] = 11'd0;
      drive(bank, idx, ($urandom_range(0, 3) == 0), di, 1'($urandom),
            ($urandom_range(0, 5) == 0), 11'($urandom),
            ($urandom_range(0, 5) == 0), 11'($urandom),
            ($urandom_range(0, 7) == 0));
    end
    idle();

    // Asynchronous reset while slot 0 is loaded and TX is busy
    wr(3'd0, 32'd0);
    tx_done_pulse();
    wr(3'd0, 32'd1);
    wr(3'd4, 32'd60);
    check("pre_reset_tx_start", bus.tx_start, 1);
    #2 sys_rst = 1'b1;
    #1;
    check("async_rst_rdy0", bus.rx_ready_0, 0);
    check("async_rst_tx_count", bus.tx_count, 0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    tx_done_pulse();
    idle();
    rd(3'd5);
    check("no_event_after_reset", bus.csr_do, 0);
    check("no_irq_after_reset", bus.irq, 0);
    idle();

    check("rd_queue_drained", rd_q.size(), 0);
    check("tx_queue_drained", tx_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/minimac3_ctrl.md
Name: minimac3_ctrl

Overview:
- System-side control stage for the minimac3 Ethernet MAC core, clocked by sys_clk and placed directly upstream of it.
- Decodes a CSR bus and runs one ownership state machine per RX buffer slot (two slots), which drives rx_ready_N and consumes rx_done_N / rx_count_N.
- Launches TX frames through tx_start/tx_count, waits for tx_done, and generates a single level interrupt.

Parameters:
CSR_ADDR, 4'h0, CSR bank number; block responds when csr_a[13:10] == CSR_ADDR.

Ports:
sys_clk  in  1  system clock, all logic on rising edge
sys_rst  in  1  asynchronous active-high reset
csr_a  in  14  CSR address; [13:10] bank select, [2:0] register index
csr_we  in  1  CSR write strobe, single cycle
csr_di  in  32  CSR write data
csr_do  out  32  CSR read data, registered
irq  out  1  interrupt, level, registered
rx_ready_0  out  1  slot 0 buffer handed to MAC
rx_done_0  in  1  one-cycle pulse: slot 0 frame complete
rx_count_0  in  11  slot 0 byte count, valid with rx_done_0
rx_ready_1  out  1  slot 1 buffer handed to MAC
rx_done_1  in  1  one-cycle pulse: slot 1 frame complete
rx_count_1  in  11  slot 1 byte count, valid with rx_done_1
tx_start  out  1  one-cycle pulse launching a TX frame
tx_done  in  1  one-cycle pulse: TX frame finished
tx_count  out  11  TX byte count, held stable from tx_start until tx_done

Behaviour:
- Reset: all registers, state machines, csr_do, irq, rx_ready_0/1, tx_start and tx_count go to 0. Reset is asynchronous and may occur mid-frame; everything returns to reset values with no pending pulses.
- Register map (index = csr_a[2:0]); unlisted indices read 0 and ignore writes:
  - 0: slot 0 state [1:0], RW.
  - 1: slot 0 count [10:0], RO.
  - 2: slot 1 state [1:0], RW.
  - 3: slot 1 count [10:0], RO.
  - 4: TX count [10:0]; a write launches TX.
  - 5: status: [0] rx_pending (RO), [1] tx_event (W1C), [2] tx_busy (RO).
  - 6: enable: [0] rx_en, [1] tx_en, RW.
- Reads: csr_do is valid one cycle after address presentation. csr_do = 0 when the bank does not match.
- Slot FSM (per slot), states EMPTY=0, LOADED=1, PENDING=2:
  - EMPTY: CSR write of 1 -> LOADED.
  - LOADED: rx_ready_N=1 (registered, asserted the cycle after the write). rx_done_N -> PENDING, count register <= rx_count_N.
  - PENDING: CSR write of 0 -> EMPTY. The count register keeps its value.
  - A CSR write of 0 from LOADED -> EMPTY (buffer reclaimed).
  - Writes of 2 or 3 are ignored. A write of 1 from PENDING is ignored.
  - rx_done_N in EMPTY or PENDING is ignored.
  - Simultaneous rx_done_N and a CSR write to the same slot: rx_done wins (-> PENDING, count latched) and the write is dropped.
- TX FSM, states IDLE and BUSY:
  - IDLE: a write to index 4 with csr_di[10:0] != 0 latches tx_count, pulses tx_start for exactly one cycle (the cycle after the write), and enters BUSY. A count of 0 is ignored.
  - BUSY: writes to index 4 are ignored. tx_done -> IDLE and sets tx_event.
  - tx_done in IDLE is ignored.
  - Same-cycle tx_done and a W1C of tx_event: set wins.
- Interrupt: rx_pending = (slot0==PENDING) | (slot1==PENDING). irq is registered: irq <= (rx_pending & rx_en) | (tx_event & tx_en).

Test Plan:
- Reset with random inputs -> csr_do, irq, rx_ready_0/1, tx_start, tx_count all 0; reads of indices 0-6 return 0.
- Write 1 to index 0, then pulse rx_done_0 with rx_count_0=11'd64 and rx_en=1 -> rx_ready_0 rises 1 cycle after the write; after the pulse, index 0 reads 2, index 1 reads 64, rx_ready_0=0, irq=1 the cycle after. Write 0 to index 0 -> irq clears.
- Load both slots; pulse rx_done_1 (count 1514) in the same cycle as a CSR write of 0 to index 2 -> slot 1 reads PENDING with count 1514; slot 0 stays LOADED.
- Write 60 to index 4 -> tx_start high for exactly 1 cycle, tx_count=60. Write 100 while BUSY -> no pulse, tx_count stays 60. tx_done -> status bit1=1, irq=1 with tx_en=1. W1C -> irq=0.
- Write 0 to index 4 -> no tx_start. Access with csr_a[13:10] != CSR_ADDR -> no state change, csr_do=0.
- Assert sys_rst while slot 0 is LOADED and TX is BUSY -> rx_ready_0=0 and tx_count=0 immediately; after release, a later tx_done produces no tx_event.
